pipeline_buffer_hs: RTL and testbench

Parametrised successor to the single-bit `pipeline_buffer` delay element. It is a WIDTH-bit, DEPTH-stage pipeline register chain with a valid/ready handshake on both sides, bubble collapsing, synchronous flush and an occupancy count. It sits between decoder datapath blocks (branch-metric, ACS and traceback stages) wherever a fixed nominal delay must also absorb downstream back-pressure.

---
 rtl/pipeline_buffer_hs_pkg.sv | 14 +
 rtl/pipeline_buffer_hs_pipe_stage.sv | 47 ++++
 rtl/pipeline_buffer_hs.sv | 98 +++++++++
 tb/tb_pipeline_buffer_hs.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_buffer_hs_pkg.sv
// Shared constants for the decoder pipeline-buffer blocks.
//   PIPE_DEPTH_MAX : deepest chain allowed. Beyond this the ip_ready
//                    combinational ripple from op_ready gets too long and
//                    a skid-register variant is needed instead.
//   cnt_w()        : width of an occupancy counter covering 0..depth.
package pipeline_buffer_hs_pkg;

  localparam int PIPE_DEPTH_MAX = 8;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipeline_buffer_hs_pipe_stage.sv
// pipe_stage: one WIDTH-bit data + valid register of the handshake chain.
// Ports:
//   clk, rst (sync, active-low) : clock / reset; reset clears data and valid
//   flush                       : clears valid on the next edge
//   ld                          : load enable (advance) for this stage
//   v_in, d_in                  : entry offered by the upstream stage
//   v_q, d_q                    : registered stage contents
module pipe_stage
  import pipeline_buffer_hs_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             ld,
  input  logic             v_in,
  input  logic [WIDTH-1:0] d_in,
  output logic             v_q,
  output logic [WIDTH-1:0] d_q
);

  logic             v_d;
  logic [WIDTH-1:0] d_d;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (ld) begin
      v_d = v_in;
      // Data bits of a bubble are don't-care; skip the write to save toggles.
      if (v_in) d_d = d_in;
    end
    if (flush) v_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

endmodule

// File: rtl/pipeline_buffer_hs.sv
// pipeline_buffer_hs: DEPTH-stage, WIDTH-bit register chain with valid/ready
// handshake on both sides, bubble collapsing, synchronous flush and a
// registered occupancy count.
// Ports:
//   clk, rst (sync, active-low)
//   ip, ip_valid, ip_ready  : upstream handshake (ip_ready combinational)
//   op, op_valid, op_ready  : downstream handshake (op from last stage)
//   flush                   : discard all contents on the next edge
//   count                   : number of valid stages
module pipeline_buffer_hs
  import pipeline_buffer_hs_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           ip,
  input  logic                       ip_valid,
  output logic                       ip_ready,
  output logic [WIDTH-1:0]           op,
  output logic                       op_valid,
  input  logic                       op_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = cnt_w(DEPTH);

  if (DEPTH < 1 || DEPTH > PIPE_DEPTH_MAX || WIDTH < 1) begin : g_bad_param
    $error("pipeline_buffer_hs: need WIDTH>=1 and 1<=DEPTH<=PIPE_DEPTH_MAX");
  end

  logic [DEPTH-1:0]            v;
  logic [DEPTH-1:0][WIDTH-1:0] d;
  logic [DEPTH-1:0]            v_in;
  logic [DEPTH-1:0][WIDTH-1:0] d_in;
  logic [DEPTH-1:0]            adv;
  logic                        acc;
  logic                        in_hs, out_hs;
  logic [CNT_W-1:0]            count_d, count_q;

  // Advance chain: a stage moves if it is empty or everything downstream of
  // it moves. Built with a running OR from the output end so the chain is a
  // plain ripple with no self-referencing vector.
  always_comb begin
    acc = op_ready;
    adv = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc    = acc | ~v[i];
      adv[i] = acc;
    end
  end

  always_comb begin
    v_in    = v << 1;
    d_in    = d << WIDTH;
    v_in[0] = ip_valid;
    d_in[0] = ip;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk  (clk),
      .rst  (rst),
      .flush(flush),
      .ld   (adv[i]),
      .v_in (v_in[i]),
      .d_in (d_in[i]),
      .v_q  (v[i]),
      .d_q  (d[i])
    );
  end

  // Handshakes are suppressed during reset and flush so nothing is taken or
  // delivered in a cycle whose contents are about to be discarded.
  assign ip_ready = adv[0] & rst & ~flush;
  assign op_valid = v[DEPTH-1] & rst & ~flush;
  assign op       = d[DEPTH-1];

  assign in_hs  = ip_valid & ip_ready;
  assign out_hs = op_valid & op_ready;

  // Stages only shift, never duplicate or drop, so occupancy changes solely
  // through the two handshakes; this tracks popcount(v) without an adder tree.
  always_comb begin
    count_d = count_q + CNT_W'(in_hs) - CNT_W'(out_hs);
    if (flush) count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: tb/tb_pipeline_buffer_hs.sv
module tb_pipeline_buffer_hs;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] ip;
  logic             ip_valid;
  logic             ip_ready;
  logic [WIDTH-1:0] op;
  logic             op_valid;
  logic             op_ready;
  logic             flush;
  logic [2:0]       count;

  int n_assert = 0;
  int n_fail   = 0;

  pipeline_buffer_hs #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .ip      (ip),
    .ip_valid(ip_valid),
    .ip_ready(ip_ready),
    .op      (op),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .flush   (flush),
    .count   (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed and outputs
  // sampled mid-cycle, well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; ip_valid = 1'b1; ip = 8'hFF; op_ready = 1'b1;

    // Reset held two cycles with input offered
    #1;
    check("rst_opv0", op_valid, 0);
    check("rst_ird0", ip_ready, 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("rst_opv", op_valid, 0);
      check("rst_ird", ip_ready, 0);
      check("rst_cnt", count, 0);
      check("rst_op", op, 0);
    end
    rst = 1'b1; ip_valid = 1'b0;
    #1;
    check("rel_ird", ip_ready, 1);
    check("rel_cnt", count, 0);
    check("rel_opv", op_valid, 0);

    // Streaming 0x01..0x10, op_ready high
    for (int c = 0; c < 20; c++) begin
      ip_valid = (c < 16);
      ip       = 8'(c + 1);
      #1;
      check("str_ird", ip_ready, 1);
      if (c >= 4) begin
        check("str_opv", op_valid, 1);
        check("str_op", op, 32'(c - 3));
      end else begin
        check("str_opv_lat", op_valid, 0);
      end
      if (c >= 4 && c <= 16) check("str_cnt", count, 4);
      tick();
    end
    check("str_empty_opv", op_valid, 0);
    check("str_empty_cnt", count, 0);

    // Back-pressure: fill A0..A3 with op_ready low
    op_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      ip_valid = 1'b1;
      ip       = 8'hA0 + 8'(c);
      #1;
      check("bp_fill_ird", ip_ready, 1);
      tick();
    end
    ip = 8'hEE;
    #1;
    check("bp_full_ird", ip_ready, 0);
    check("bp_full_cnt", count, 4);
    check("bp_full_op", op, 8'hA0);
    tick();
    check("bp_hold_ird", ip_ready, 0);
    check("bp_hold_cnt", count, 4);
    ip_valid = 1'b0; op_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("bp_drain_opv", op_valid, 1);
      check("bp_drain_op", op, 32'hA0 + 32'(c));
      tick();
    end
    check("bp_drain_end_opv", op_valid, 0);
    check("bp_drain_end_cnt", count, 0);

    // Bubble collapse: 0x11, gap, gap, 0x22 with op_ready low
    op_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      ip_valid = (c == 0) || (c == 3);
      ip       = (c == 0) ? 8'h11 : 8'h22;
      #1;
      check("bub_ird", ip_ready, 1);
      tick();
    end
    ip_valid = 1'b0;
    #1;
    check("bub_cnt2", count, 2);
    check("bub_op11", op, 8'h11);
    check("bub_opv", op_valid, 1);
    ip_valid = 1'b1; ip = 8'h33;
    #1;
    check("bub_ird33", ip_ready, 1);
    tick();
    ip = 8'h44;
    #1;
    check("bub_ird44", ip_ready, 1);
    tick();
    ip = 8'h99;
    #1;
    check("bub_full_ird", ip_ready, 0);
    check("bub_full_cnt", count, 4);
    // Pop one so three remain for the flush
    ip_valid = 1'b0; op_ready = 1'b1;
    #1;
    check("bub_pop11", op, 8'h11);
    tick();
    op_ready = 1'b0;
    #1;
    check("bub_adj22", op, 8'h22);
    check("bub_cnt3", count, 3);

    // Flush with 3 held, same cycle as input 0x55
    flush = 1'b1; ip_valid = 1'b1; ip = 8'h55; op_ready = 1'b1;
    #1;
    check("fl_ird", ip_ready, 0);
    check("fl_opv", op_valid, 0);
    tick();
    flush = 1'b0; ip_valid = 1'b0;
    #1;
    check("fl_cnt", count, 0);
    check("fl_opv_next", op_valid, 0);
    for (int c = 0; c < DEPTH + 1; c++) begin
      tick();
      check("fl_no55_opv", op_valid, 0);
    end

    // Simultaneous in/out handshake at count 2
    op_ready = 1'b0; ip_valid = 1'b1; ip = 8'h61;
    tick();
    ip = 8'h62;
    tick();
    ip_valid = 1'b0;
    tick();
    tick();
    check("sim_cnt_pre", count, 2);
    ip_valid = 1'b1; ip = 8'h63; op_ready = 1'b1;
    #1;
    check("sim_ird", ip_ready, 1);
    check("sim_op61", op, 8'h61);
    tick();
    ip_valid = 1'b0; op_ready = 1'b0;
    #1;
    check("sim_cnt_post", count, 2);
    check("sim_op62", op, 8'h62);

    // Reset and flush together: reset wins (data cleared too)
    rst = 1'b0; flush = 1'b1;
    #1;
    check("rf_ird", ip_ready, 0);
    check("rf_opv", op_valid, 0);
    tick();
    check("rf_cnt", count, 0);
    check("rf_op", op, 0);
    rst = 1'b1; flush = 1'b0;
    #1;
    check("rf_rel_ird", ip_ready, 1);
    check("rf_rel_opv", op_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
